// File: rtl/bidir_bus_arbiter.sv
// Round-robin owner of a shared tri-state bus between requesters A and B.
// Sequences fixed-length bursts, mirrors each word to the opposite side, and idles the bus between owners.
module bidir_bus_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = 4,
  parameter int TURNAROUND = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_a,
  input  logic [LEN_W-1:0]      len_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic                  gnt_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic                  rvalid_a,
  input  logic                  req_b,
  input  logic [LEN_W-1:0]      len_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  gnt_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  rvalid_b,
  inout  wire  [DATA_WIDTH-1:0] bus_data,
  output logic                  busy
);

  localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [TW-1:0] TURN_LOAD = TW'(TURNAROUND - 1);

  typedef enum logic [1:0] {IDLE, DRIVE_A, DRIVE_B, TURN} state_t;

  state_t                state, state_nxt;
  logic [LEN_W-1:0]      cnt, cnt_nxt;
  logic [TW-1:0]         turn_cnt, turn_cnt_nxt;
  // Set when B owned the bus most recently, so A wins the next tie.
  logic                  last_b, last_b_nxt;

  logic                  drv_a, drv_b, drv_en;
  logic [DATA_WIDTH-1:0] bus_out;

  logic [DATA_WIDTH-1:0] cap_a_p1, cap_b_p1;
  logic                  vld_a_p1, vld_b_p1;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    turn_cnt_nxt = turn_cnt;
    last_b_nxt   = last_b;
    case (state)
      IDLE: begin
        if (req_a && (!req_b || last_b)) begin
          state_nxt = DRIVE_A;
          cnt_nxt   = (len_a == '0) ? LEN_W'(1) : len_a;
        end else if (req_b) begin
          state_nxt = DRIVE_B;
          cnt_nxt   = (len_b == '0) ? LEN_W'(1) : len_b;
        end
      end
      DRIVE_A: begin
        cnt_nxt = cnt - LEN_W'(1);
        if (!req_a || cnt == LEN_W'(1)) begin
          state_nxt    = TURN;
          last_b_nxt   = 1'b0;
          turn_cnt_nxt = TURN_LOAD;
        end
      end
      DRIVE_B: begin
        cnt_nxt = cnt - LEN_W'(1);
        if (!req_b || cnt == LEN_W'(1)) begin
          state_nxt    = TURN;
          last_b_nxt   = 1'b1;
          turn_cnt_nxt = TURN_LOAD;
        end
      end
      TURN: begin
        if (turn_cnt == '0) state_nxt = IDLE;
        else                turn_cnt_nxt = turn_cnt - TW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      turn_cnt <= '0;
      last_b   <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      turn_cnt <= turn_cnt_nxt;
      last_b   <= last_b_nxt;
    end
  end

  // Enables decode only registered state, so they cannot glitch on req edges.
  assign drv_a    = (state == DRIVE_A);
  assign drv_b    = (state == DRIVE_B);
  assign drv_en   = drv_a | drv_b;
  assign bus_out  = drv_b ? wdata_b : wdata_a;
  assign bus_data = drv_en ? bus_out : {DATA_WIDTH{1'bz}};

  assign gnt_a = drv_a;
  assign gnt_b = drv_b;
  assign busy  = (state != IDLE);

  // Stage p1: word seen on the bus, delivered to the non-driving side.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_a_p1 <= 1'b0;
      vld_b_p1 <= 1'b0;
      cap_a_p1 <= '0;
      cap_b_p1 <= '0;
    end else begin
      vld_a_p1 <= drv_b;
      vld_b_p1 <= drv_a;
      if (drv_b) cap_a_p1 <= bus_out;
      if (drv_a) cap_b_p1 <= bus_out;
    end
  end

  assign rdata_a  = cap_a_p1;
  assign rvalid_a = vld_a_p1;
  assign rdata_b  = cap_b_p1;
  assign rvalid_b = vld_b_p1;

endmodule
